uart8_tx: RTL and testbench
===========================

# uart8_tx

Transmit half of the 8N1 UART, the counterpart of the `Uart8` receiver path. It accepts one byte at a time over a start/ready handshake into a one-byte holding register. It serializes the byte LSB-first on `txOut` at `BAUD_RATE`, with one start bit and one stop bit, and drives the line back to idle-high between frames. It sits beside the receiver under the same `clk`. The holding register allows back-to-back frames with no idle gap on the line.

## Interface
- `CLOCK_RATE`, default 12000000: `clk` frequency in Hz.
- `BAUD_RATE`, default 9600: line bit rate in Hz.
- `BIT_DIV`, derived, not overridable: round(CLOCK_RATE/BAUD_RATE) = (CLOCK_RATE + BAUD_RATE/2) / BAUD_RATE. At the defaults this is 1250.

Ports:
- `clk`  in  1: single clock.
- `reset`  in  1: asynchronous, active-low. Asserting it forces all state to reset values immediately.
- `txEn`  in  1: transmitter enable.
- `txStart`  in  1: request to accept `txData`. It is sampled on the rising edge.
- `txData`  in  8: byte to send. It is captured when `txStart & txReady`.
- `txReady`  out  1: the holding register is empty, so a start request will be accepted.
- `txBusy`  out  1: a frame is on the line (any state other than IDLE).
- `txDone`  out  1: one-cycle pulse at the end of each stop bit.
- `txOut`  out  1: serial line, idle high.

## Operation
- Reset values: `txOut`=1, `txBusy`=0, `txDone`=0, `txReady`=1. After reset, state is IDLE, the holding register is empty, and the bit counter and baud counter are 0.
- Accept: on any edge with `txStart & txReady`, `txData` is loaded into the holding register and `txReady` goes to 0.
- `txStart` is ignored while `txReady`=0. No error is flagged and the holding register is not overwritten.
- `txReady` goes back to 1 when the holding byte moves into the shift register.
- State machine: IDLE -> START -> DATA -> STOP.
  - IDLE: if the holding register is full and `txEn`=1, load the shifter, clear the baud counter and go to START.
  - START: `txOut`=0 for BIT_DIV cycles, then go to DATA with bit index 0.
  - DATA: `txOut`=shifter[0] for BIT_DIV cycles, then shift right and increment the index. After index 7, go to STOP.
  - STOP: `txOut`=1 for BIT_DIV cycles. On the last cycle, pulse `txDone`. If the holding register is full and `txEn`=1, go directly to START and load the shifter. Otherwise go to IDLE.
- Deasserting `txEn` mid-frame does not abort: the current frame completes. No new frame starts while `txEn`=0. A byte already in the holding register is retained and sent once `txEn` returns to 1.
- Reset asserted mid-frame: `txOut` returns to 1 asynchronously and the frame is lost. The holding register content is discarded.
- Baud counter: counts 0..BIT_DIV-1 and wraps. Its width is $clog2(BIT_DIV).

## Timing
- Accept at edge N. If idle, the state enters START at edge N+1, so `txOut` falls after edge N+1. `txReady` is 1 again after edge N+1.
- Every bit lasts exactly BIT_DIV cycles. A full frame is 10*BIT_DIV cycles (12500 at the defaults).
- `txDone` is high for exactly the final cycle of the stop bit.
- `txBusy` is high from the first START cycle through the last STOP cycle. It stays high across back-to-back frames.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop cycle, with zero idle cycles.
- Byte sequence 0xD6 on the line: 0 (start), then 0,1,1,0,1,0,1,1, then 1 (stop).

## Structure
- Package `uart_pkg`:
  - `tx_state_t` enum (IDLE, START, DATA, STOP);
  - `bit_div(clock, baud)` rounding function;
  - constants DATA_BITS=8 and STOP_BITS=1, shared with the receiver.
- Sub-module `uart_baud_tick`, parameterised by BIT_DIV:
  - inputs: `clk`, `reset`, synchronous `clear`;
  - output: `tick`, high on count BIT_DIV-1.
  - The FSM advances only on `tick`.

## Test plan
- Reset: hold `reset`=0 for 10 cycles. Required: `txOut`=1, `txBusy`=0, `txReady`=1 and `txDone`=0 throughout. After release, the line stays idle with no `txStart`.
- Single byte: send 0xD6 at the defaults. Required line sequence is 0,0,1,1,0,1,0,1,1,1, each level held for 1250 cycles. `txDone` must pulse exactly once, 12500 cycles after the start bit began. Feeding the line into `Uart8` must give `rxOut`=0xD6 with `rxErr`=0.
- Back-to-back: send 0xD6, then 0x3C while the first frame is in DATA. Required: the second start bit begins the cycle after the first `txDone`, and `txBusy` never drops. A third `txStart` while `txReady`=0 is ignored.
- Enable gating: load 0xA5 with `txEn`=0. Required: `txOut` stays 1 and `txReady`=0. Raising `txEn` then starts the frame one cycle later.
- Enable drop mid-frame: lower `txEn` during DATA. Required: the frame completes intact, and a queued byte is held until `txEn`=1.
- Reset mid-frame: assert `reset` during bit 3. Required: `txOut`=1 immediately, without waiting for `clk`. After release, all outputs are at reset values and the queued byte is gone.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int unsigned bit_div(input int unsigned clock, input int unsigned baud);
    return (clock + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..BIT_DIV-1 and flags the last cycle of each bit.
module uart_baud_tick #(
  parameter int unsigned BIT_DIV = 1250
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

  logic [CNT_W-1:0] cntQ, cntD;

  assign tick = (cntQ == CNT_W'(BIT_DIV - 1));

  // Next count: synchronous clear wins, otherwise wrap on the last cycle.
  always_comb begin
    cntD = cntQ + CNT_W'(1);
    if (clear || tick) cntD = '0;
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cntQ <= '0;
    else        cntQ <= cntD;
  end

endmodule

// File: rtl/uart8_tx.sv
// 8N1 UART transmitter with a one-byte holding register for gap-free frames.
module uart8_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_RATE = 12000000,
  parameter int unsigned BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] txData,
  output logic       txReady,
  output logic       txBusy,
  output logic       txDone,
  output logic       txOut
);

  localparam int unsigned BIT_DIV = bit_div(CLOCK_RATE, BAUD_RATE);
  localparam int unsigned IDX_W   = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  tx_state_t stateQ, stateD;

  logic [7:0]       holdQ, holdD;
  logic             holdFullQ, holdFullD;
  logic [7:0]       shiftQ, shiftD;
  logic [IDX_W-1:0] bitIdxQ, bitIdxD;
  logic             tick;
  logic             accept;
  logic             loadShift;

  // Counter is held at zero while idle so the start bit gets a full period.
  uart_baud_tick #(
    .BIT_DIV(BIT_DIV)
  ) uBaud (
    .clk  (clk),
    .reset(reset),
    .clear(stateQ == IDLE),
    .tick (tick)
  );

  assign txReady   = !holdFullQ;
  assign accept    = txStart && !holdFullQ;
  // Shifter is refilled from idle, or straight from the final stop cycle.
  assign loadShift = ((stateQ == IDLE) || ((stateQ == STOP) && tick)) && holdFullQ && txEn;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stateQ <= IDLE;
    else        stateQ <= stateD;
  end

  // Next-state logic; a started frame always runs to its stop bit.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE:    if (holdFullQ && txEn) stateD = START;
      START:   if (tick) stateD = DATA;
      DATA:    if (tick && (bitIdxQ == LAST_IDX)) stateD = STOP;
      STOP:    if (tick) stateD = (holdFullQ && txEn) ? START : IDLE;
      default: stateD = IDLE;
    endcase
  end

  // Line and status outputs decoded from state.
  always_comb begin
    txOut  = 1'b1;
    txBusy = 1'b1;
    txDone = 1'b0;
    unique case (stateQ)
      IDLE:    txBusy = 1'b0;
      START:   txOut  = 1'b0;
      DATA:    txOut  = shiftQ[0];
      STOP:    txDone = tick;
      default: txBusy = 1'b0;
    endcase
  end

  // Holding register, shifter and bit index next-state.
  always_comb begin
    holdD     = holdQ;
    holdFullD = holdFullQ;
    shiftD    = shiftQ;
    bitIdxD   = bitIdxQ;
    if (loadShift) begin
      shiftD    = holdQ;
      holdFullD = 1'b0;
    end else if ((stateQ == DATA) && tick) begin
      shiftD  = {1'b0, shiftQ[7:1]};
      bitIdxD = bitIdxQ + IDX_W'(1);
    end
    if ((stateQ == START) && tick) bitIdxD = '0;
    // accept and loadShift are exclusive: loading needs a full holding register.
    if (accept) begin
      holdD     = txData;
      holdFullD = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      holdQ     <= '0;
      holdFullQ <= 1'b0;
      shiftQ    <= '0;
      bitIdxQ   <= '0;
    end else begin
      holdQ     <= holdD;
      holdFullQ <= holdFullD;
      shiftQ    <= shiftD;
      bitIdxQ   <= bitIdxD;
    end
  end

endmodule

// File: tb/tb_uart8_tx.sv
// Scoreboard bench for uart8_tx: stimulus queues expected bytes, a line monitor decodes frames.
module tb_uart8_tx;

  // round(1000/75) = round(13.33) = 13 cycles per bit.
  localparam int BD  = 13;
  localparam int LIM = 40 * BD;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       txEn = 1'b1;
  logic       txStart = 1'b0;
  logic [7:0] txData = 8'h00;
  logic       txReady, txBusy, txDone, txOut;

  int passCnt  = 0;
  int totalCnt = 0;
  bit monEn    = 1'b1;
  logic [7:0] sbq[$];

  uart8_tx #(
    .CLOCK_RATE(1000),
    .BAUD_RATE (75)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .txEn   (txEn),
    .txStart(txStart),
    .txData (txData),
    .txReady(txReady),
    .txBusy (txBusy),
    .txDone (txDone),
    .txOut  (txOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic sendByte(input logic [7:0] b, input bit push);
    int n = 0;
    while (txReady !== 1'b1 && n < LIM) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", txReady, 1);
    txStart = 1'b1;
    txData  = b;
    if (push) sbq.push_back(b);
    @(negedge clk);
    txStart = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (txDone !== 1'b1 && n < LIM) begin
      @(negedge clk);
      n++;
    end
    chk(name, txDone, 1);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (!(sbq.size() == 0 && txBusy === 1'b0 && txReady === 1'b1) && n < LIM) begin
      @(negedge clk);
      n++;
    end
    chk(name, {sbq.size() == 0, txBusy, txReady}, 3'b101);
  endtask

  // Count cycles where the line is not idle or status differs from the given ready level.
  task automatic holdIdle(input string name, input int cycles, input logic ready);
    int viol = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (txOut !== 1'b1 || txBusy !== 1'b0 || txReady !== ready || txDone !== 1'b0) viol++;
    end
    chk(name, viol, 0);
  endtask

  // Line monitor: decode each frame and compare against the scoreboard.
  initial begin
    logic [7:0] data;
    logic       lvl;
    logic       stopLvl;
    int         bad;
    int         doneCnt;
    int         qs;
    forever begin
      do @(negedge clk); while (!(monEn && txOut === 1'b0));
      bad     = 0;
      doneCnt = 0;
      data    = 8'h00;
      lvl     = 1'b0;
      stopLvl = 1'b0;
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < BD; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (c == 0) lvl = txOut;
          else if (txOut !== lvl) bad++;
          if (txBusy !== 1'b1) bad++;
          if (txDone === 1'b1) begin
            if (b == 9 && c == BD - 1) doneCnt++;
            else bad++;
          end else if (txDone !== 1'b0) bad++;
        end
        if (b >= 1 && b <= 8) data[b-1] = lvl;
        if (b == 9) stopLvl = lvl;
      end
      qs = sbq.size();
      if (qs == 0) chk("frame_queued", qs, 1);
      else chk("frame_data", data, sbq.pop_front());
      chk("frame_stop", stopLvl, 1);
      chk("frame_shape", bad, 0);
      chk("frame_done", doneCnt, 1);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset held for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("reset_hold", {txOut, txBusy, txReady, txDone}, 4'b1010);
    end
    reset = 1'b1;
    holdIdle("post_reset_idle", 20, 1'b1);

    // Single byte 0xD6: line 0,0,1,1,0,1,0,1,1,1.
    sendByte(8'hD6, 1'b1);
    chk("accept_line_still_idle", {txOut, txReady}, 2'b10);
    @(negedge clk);
    chk("start_bit_next_cycle", {txOut, txReady, txBusy}, 3'b011);
    waitIdle("single_idle");

    // Back-to-back 0xD6, 0x3C; extra request while full is dropped.
    sendByte(8'hD6, 1'b1);
    repeat (3 * BD) @(negedge clk);
    sendByte(8'h3C, 1'b1);
    chk("b2b_ready_low", txReady, 0);
    txStart = 1'b1;
    txData  = 8'hFF;
    @(negedge clk);
    txStart = 1'b0;
    waitDone("b2b_done1");
    @(negedge clk);
    chk("b2b_no_gap", {txOut, txBusy}, 2'b01);
    waitIdle("b2b_idle");
    holdIdle("b2b_no_third", 2 * BD, 1'b1);

    // Enable gating: byte waits in the holding register.
    txEn = 1'b0;
    sendByte(8'hA5, 1'b1);
    holdIdle("gate_hold", 3 * BD, 1'b0);
    txEn = 1'b1;
    @(negedge clk);
    chk("gate_start", {txOut, txBusy}, 2'b01);
    waitIdle("gate_idle");

    // Enable dropped mid-frame: frame completes, queued byte held.
    sendByte(8'h5A, 1'b1);
    repeat (3 * BD) @(negedge clk);
    sendByte(8'h81, 1'b1);
    txEn = 1'b0;
    waitDone("endrop_done");
    holdIdle("endrop_hold", 3 * BD, 1'b0);
    txEn = 1'b1;
    waitIdle("endrop_idle");

    // Reset during data bit 3 with a byte queued.
    monEn = 1'b0;
    sendByte(8'h00, 1'b0);
    begin
      int n = 0;
      while (txOut !== 1'b0 && n < LIM) begin
        @(negedge clk);
        n++;
      end
      chk("rst_frame_started", txOut, 0);
    end
    sendByte(8'h42, 1'b0);
    repeat (4 * BD + BD / 2 - 1) @(negedge clk);
    #2;
    chk("rst_pre_low", {txOut, txReady}, 2'b00);
    reset = 1'b0;
    #1;
    chk("rst_async", {txOut, txBusy, txReady, txDone}, 4'b1010);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk("rst_release", {txOut, txBusy, txReady, txDone}, 4'b1010);
    holdIdle("rst_queue_gone", 3 * BD, 1'b1);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
